// File: rtl/prog_loader.sv
// Serial bootstrap loader: receives a big-endian word-count header plus data words over
// an 8N1 UART line, writes them into program RAM from address 0, and holds the CPU until done.
module prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] ld_addr,
    output logic [15:0] ld_data,
    output logic        ld_wren,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0]      DEPTH_W   = 17'(DEPTH);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] HDR_HI = 3'd0;
    localparam logic [2:0] HDR_LO = 3'd1;
    localparam logic [2:0] DAT_HI = 3'd2;
    localparam logic [2:0] DAT_LO = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    logic             rx_meta;
    logic             rx_sync;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             frame_err;

    logic [2:0]       ld_state;
    logic [7:0]       n_hi;
    logic [15:0]      n_words;
    logic [7:0]       data_hi;
    logic             terminal;

    // NOTE: every clocked block below uses non-blocking (<=) assignments so that all
    // registers sample their inputs from the same edge; blocking (=) here would make the
    // second synchroniser flop see the first flop's new value and collapse the chain.
    // Reset to 1 so an idle line does not look like a start bit coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte    <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign terminal = (ld_state == DONE) || (ld_state == ERR);

    // ld_wren is registered on entry to WRITE, so it is high for exactly the WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_state     <= HDR_HI;
            n_hi         <= '0;
            n_words      <= '0;
            data_hi      <= '0;
            ld_addr      <= '0;
            ld_data      <= '0;
            ld_wren      <= 1'b0;
            words_loaded <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            ld_wren <= 1'b0;
            case (ld_state)
                HDR_HI: begin
                    if (byte_valid) begin
                        n_hi     <= rx_byte;
                        ld_state <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (byte_valid) begin
                        n_words <= {n_hi, rx_byte};
                        if ({n_hi, rx_byte} == 16'd0) begin
                            ld_state <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if ({1'b0, n_hi, rx_byte} > DEPTH_W) begin
                            ld_state <= ERR;
                            err      <= 1'b1;
                        end else begin
                            ld_state <= DAT_HI;
                        end
                    end
                end
                DAT_HI: begin
                    if (byte_valid) begin
                        data_hi  <= rx_byte;
                        ld_state <= DAT_LO;
                    end
                end
                DAT_LO: begin
                    if (byte_valid) begin
                        ld_addr  <= words_loaded;
                        ld_data  <= {data_hi, rx_byte};
                        ld_wren  <= 1'b1;
                        ld_state <= WRITE;
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + 16'd1;
                    if (words_loaded == n_words - 16'd1) begin
                        ld_state <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        ld_state <= DAT_HI;
                    end
                end
                default: ;
            endcase
            // A framing error overrides whatever the case above chose; the write in
            // progress (if any) has already reached the RAM and is still counted.
            if (frame_err && !terminal) begin
                ld_state <= ERR;
                err      <= 1'b1;
                done     <= 1'b0;
                cpu_hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table vectors, hand-written corner sequences and
// random images compared against an image-level reference model.
module tb_prog_loader;

    localparam int CPB   = 4;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_wren;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    prog_loader #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_wren(ld_wren),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bytes;
        int          nbytes;
        int          bad;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_words;
        logic [15:0] exp_last;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    logic [15:0] act_addr[$];
    logic [15:0] act_data[$];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic        exp_done;
    logic        exp_err;
    logic [7:0]  tx_bytes[$];
    int          tx_bad;
    int          last_wren_cycle;
    logic        prev_wren;
    logic        prev_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Observer: collects every RAM write and checks pulse width and done timing.
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            prev_wren = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (ld_wren) begin
                check("wren_single_cycle", {31'd0, prev_wren}, 32'd0);
                act_addr.push_back(ld_addr);
                act_data.push_back(ld_data);
                last_wren_cycle = cycle;
            end
            if (done && !prev_done && last_wren_cycle >= 0)
                check("done_one_cycle_after_last_write", cycle - last_wren_cycle, 32'd1);
            prev_wren = ld_wren;
            prev_done = done;
        end
    end

    task automatic clear_obs();
        act_addr.delete();
        act_data.delete();
        last_wren_cycle = -1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ld_addr", {16'd0, ld_addr}, 32'd0);
        check("rst_ld_data", {16'd0, ld_data}, 32'd0);
        check("rst_ld_wren", {31'd0, ld_wren}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
        rx = 1'b1;
    endtask

    // Frames go out back to back; a deliberately bad frame is followed by idle time.
    task automatic send_all();
        for (int i = 0; i < tx_bytes.size(); i++) begin
            send_frame(tx_bytes[i], (i == tx_bad) ? 1'b0 : 1'b1);
            if (i == tx_bad) begin
                hold_bit(1'b1);
                hold_bit(1'b1);
            end
        end
        repeat (3) hold_bit(1'b1);
    endtask

    // Reference model: parses the image as a whole from the byte list and the
    // position of the corrupted frame.
    task automatic build_expect();
        int n;
        int nwr;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n   = (int'(tx_bytes[0]) << 8) + int'(tx_bytes[1]);
        nwr = 0;
        if (tx_bad >= 0 && tx_bad < 2) begin
            exp_err = 1'b1;
        end else if (n > DEPTH) begin
            exp_err = 1'b1;
        end else if (tx_bad >= 0 && tx_bad < 2 + 2 * n) begin
            exp_err = 1'b1;
            nwr = (tx_bad - 2) / 2;
        end else begin
            exp_done = 1'b1;
            nwr = n;
        end
        for (int i = 0; i < nwr; i++) begin
            exp_addr.push_back(16'(i));
            exp_data.push_back({tx_bytes[2 + 2 * i], tx_bytes[3 + 2 * i]});
        end
    endtask

    task automatic compare_results(input string tag);
        int m;
        build_expect();
        check({tag, "_write_count"}, act_addr.size(), exp_addr.size());
        m = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_addr"}, {16'd0, act_addr[i]}, {16'd0, exp_addr[i]});
            check({tag, "_data"}, {16'd0, act_data[i]}, {16'd0, exp_data[i]});
        end
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_words"}, {16'd0, words_loaded}, exp_addr.size());
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [15:0] last;
        int n;

        vecs[0] = '{64'h0002_1234_ABCD_5566, 8, -1, 1'b1, 1'b0, 16'd2, 16'hABCD};
        vecs[1] = '{64'h0000_1234_0000_0000, 4, -1, 1'b1, 1'b0, 16'd0, 16'h0000};
        vecs[2] = '{64'h0101_AABB_0000_0000, 4, -1, 1'b0, 1'b1, 16'd0, 16'h0000};
        vecs[3] = '{64'h0002_1122_3344_5566, 8,  4, 1'b0, 1'b1, 16'd1, 16'h1122};
        vecs[4] = '{64'h0001_BEEF_0000_0000, 4, -1, 1'b1, 1'b0, 16'd1, 16'hBEEF};

        rst = 1'b1;
        rx  = 1'b1;
        last_wren_cycle = -1;

        for (int v = 0; v < 5; v++) begin
            apply_reset();
            tx_bytes.delete();
            for (int i = 0; i < vecs[v].nbytes; i++)
                tx_bytes.push_back(vecs[v].bytes[63 - 8 * i -: 8]);
            tx_bad = vecs[v].bad;
            send_all();
            last = (act_data.size() > 0) ? act_data[act_data.size() - 1] : 16'h0000;
            check("vec_done", {31'd0, done}, {31'd0, vecs[v].exp_done});
            check("vec_err", {31'd0, err}, {31'd0, vecs[v].exp_err});
            check("vec_words", {16'd0, words_loaded}, {16'd0, vecs[v].exp_words});
            check("vec_last_data", {16'd0, last}, {16'd0, vecs[v].exp_last});
            compare_results("vec");
        end

        // Full-depth image: N = DEPTH.
        apply_reset();
        tx_bytes.delete();
        tx_bytes.push_back(8'h01);
        tx_bytes.push_back(8'h00);
        for (int i = 0; i < 2 * DEPTH; i++) tx_bytes.push_back(8'($urandom));
        tx_bad = -1;
        send_all();
        check("full_last_addr", (act_addr.size() > 0) ? {16'd0, act_addr[act_addr.size() - 1]} : 32'hFFFF_FFFF, 32'h0000_00FF);
        check("full_words", {16'd0, words_loaded}, 32'd256);
        compare_results("full");

        // One-clock glitch in idle, then a normal image.
        apply_reset();
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("glitch_no_write", act_addr.size(), 32'd0);
        tx_bytes = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        tx_bad = -1;
        send_all();
        compare_results("glitch");

        // Reset during the third data frame, then a fresh image.
        apply_reset();
        tx_bytes = '{8'h00, 8'h03, 8'hAA, 8'h55};
        tx_bad = -1;
        send_all();
        check("midload_first_write", (act_data.size() == 1) ? {16'd0, act_data[0]} : 32'hFFFF_FFFF, 32'h0000_AA55);
        check("midload_not_done", {31'd0, done}, 32'd0);
        rx = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        apply_reset();
        tx_bytes = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        send_all();
        compare_results("after_reset");

        // Random images against the reference model.
        for (int t = 0; t < 20; t++) begin
            apply_reset();
            n = ($urandom_range(0, 5) == 0) ? 257 + int'($urandom_range(0, 100)) : int'($urandom_range(0, 6));
            tx_bytes.delete();
            tx_bytes.push_back(8'(n >> 8));
            tx_bytes.push_back(8'(n));
            for (int i = 0; i < ((n > DEPTH) ? 4 : 2 * n) + 2; i++)
                tx_bytes.push_back(8'($urandom));
            tx_bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, tx_bytes.size() - 1)) : -1;
            send_all();
            compare_results("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
